// File: rtl/filter_mode_scheduler_if.sv
`timescale 1ns/1ps
// filter_mode_scheduler_if: bundles the balance/identify requests and the filter-bank outputs.
// Latency: none; this is wiring only.
// Backpressure: none; the requester holds i_id_req as a level. o_timeout exists only with FILTER_SCHED_TIMEOUT_EN.
interface filter_mode_scheduler_if;
  logic [1:0] i_bal_sel;
  logic       i_id_req;
  logic [1:0] i_id_sel;
  logic       i_id_done;
  logic [1:0] o_filter_select_out;
  logic       o_ready;
  logic       o_settling;
`ifdef FILTER_SCHED_TIMEOUT_EN
  logic       o_timeout;
`endif

  // Driver side: supplies the requests and observes the scheduler outputs.
  modport master (
`ifdef FILTER_SCHED_TIMEOUT_EN
    input  o_timeout,
`endif
    output i_bal_sel,
    output i_id_req,
    output i_id_sel,
    output i_id_done,
    input  o_filter_select_out,
    input  o_ready,
    input  o_settling
  );

  // Scheduler side.
  modport slave (
`ifdef FILTER_SCHED_TIMEOUT_EN
    output o_timeout,
`endif
    input  i_bal_sel,
    input  i_id_req,
    input  i_id_sel,
    input  i_id_done,
    output o_filter_select_out,
    output o_ready,
    output o_settling
  );
endinterface

// File: rtl/filter_mode_scheduler.sv
`timescale 1ns/1ps
// filter_mode_scheduler: arbitrates the shared filter bank between the balance loop and identify logic.
// Latency: one clk from any input to every output; all outputs are registers.
// Backpressure: identify waits for MIN_HOLD plus the settle window; FILTER_SCHED_TIMEOUT_EN adds an ID watchdog.
module filter_mode_scheduler #(
  parameter int SETTLE_CYCLES = 8,
  parameter int MIN_HOLD      = 32,
  parameter int ID_TIMEOUT    = 1000
) (
  input logic                    clk,
  input logic                    rst,
  filter_mode_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_BAL     = 2'd0,
    ST_SET_ID  = 2'd1,
    ST_ID      = 2'd2,
    ST_SET_BAL = 2'd3
  } state_t;

  // A settle window of N cycles is entered with N-1 and leaves on the cycle it reads 0.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [9:0] HOLD_MAX    = 10'(MIN_HOLD);

  state_t     r_state;
  logic [9:0] r_hold;
  logic [7:0] r_settle;
  logic [1:0] r_sel;
  logic       r_ready;
  logic       r_settling;

  logic       w_hold_met;
  logic       w_settle_done;
  logic       w_wd_expired;
  logic       w_id_exit;

`ifdef FILTER_SCHED_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(ID_TIMEOUT - 1);

  logic [15:0] r_wd;
  logic        r_timeout;

  // The watchdog trips on the ID_TIMEOUT-th cycle spent in ID.
  assign w_wd_expired  = (r_state == ST_ID) && (r_wd == WD_LAST);
  assign bus.o_timeout = r_timeout;
`else
  // Without the watchdog, identify may keep the filter for as long as it asks.
  logic w_unused_id_timeout;
  assign w_unused_id_timeout = ^16'(ID_TIMEOUT);
  assign w_wd_expired        = 1'b0;
`endif

  assign w_hold_met    = (r_hold == HOLD_MAX);
  assign w_settle_done = (r_settle == 8'd0);
  // id_done takes priority simply by being one of the exit causes; all causes lead to SET_BAL.
  assign w_id_exit     = bus.i_id_done || !bus.i_id_req || w_wd_expired;

  // State, counters and outputs advance together; outputs reflect the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BAL;
      r_hold     <= '0;
      r_settle   <= '0;
      r_sel      <= 2'b00;
      r_ready    <= 1'b0;
      r_settling <= 1'b0;
`ifdef FILTER_SCHED_TIMEOUT_EN
      r_wd       <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_BAL: begin
          if (bus.i_id_req && w_hold_met) begin
            r_state    <= ST_SET_ID;
            r_settle   <= SETTLE_LAST;
            r_sel      <= bus.i_id_sel;
            r_settling <= 1'b1;
          end else begin
            r_sel <= bus.i_bal_sel;
            if (!w_hold_met) begin
              r_hold <= r_hold + 10'd1;
            end
          end
        end

        ST_SET_ID: begin
          if (!w_settle_done) begin
            r_settle <= r_settle - 8'd1;
            r_sel    <= bus.i_id_sel;
          end else if (bus.i_id_req) begin
            r_state    <= ST_ID;
            r_sel      <= bus.i_id_sel;
            r_ready    <= 1'b1;
            r_settling <= 1'b0;
`ifdef FILTER_SCHED_TIMEOUT_EN
            r_wd       <= '0;
`endif
          end else begin
            // Requester gave up during the settle: hand the filter straight back.
            r_state  <= ST_SET_BAL;
            r_settle <= SETTLE_LAST;
            r_sel    <= bus.i_bal_sel;
          end
        end

        ST_ID: begin
          if (w_id_exit) begin
            r_state    <= ST_SET_BAL;
            r_settle   <= SETTLE_LAST;
            r_sel      <= bus.i_bal_sel;
            r_ready    <= 1'b0;
            r_settling <= 1'b1;
          end else begin
            r_sel <= bus.i_id_sel;
`ifdef FILTER_SCHED_TIMEOUT_EN
            r_wd  <= r_wd + 16'd1;
`endif
          end
`ifdef FILTER_SCHED_TIMEOUT_EN
          if (w_wd_expired) begin
            r_timeout <= 1'b1;
          end
`endif
        end

        ST_SET_BAL: begin
          // id_req is deliberately not looked at here; the balance loop always gets its hold time.
          r_sel <= bus.i_bal_sel;
          if (!w_settle_done) begin
            r_settle <= r_settle - 8'd1;
          end else begin
            r_state    <= ST_BAL;
            r_hold     <= '0;
            r_settling <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_BAL;
        end
      endcase
    end
  end

  assign bus.o_filter_select_out = r_sel;
  assign bus.o_ready             = r_ready;
  assign bus.o_settling          = r_settling;

endmodule

// File: tb/tb_filter_mode_scheduler.sv
`timescale 1ns/1ps
// tb_filter_mode_scheduler: directed scenarios followed by random traffic, checked against a phase/age model.
// Latency: outputs are compared on the falling edge after each rising edge.
// Backpressure: not applicable; the bench drives every input each cycle.
module tb_filter_mode_scheduler;
  localparam int P_SETTLE = 8;
  localparam int P_HOLD   = 32;
  localparam int P_TO     = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  filter_mode_scheduler_if bus();

  filter_mode_scheduler #(
    .SETTLE_CYCLES(P_SETTLE),
    .MIN_HOLD     (P_HOLD),
    .ID_TIMEOUT   (P_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the filter, how long it has owned it, and how much settle time is left.
  typedef enum int {M_BAL, M_SET_ID, M_ID, M_SET_BAL} mphase_t;
  mphase_t    m_phase;
  int         m_bal_age;
  int         m_left;
  int         m_id_age;
  logic [1:0] m_sel;
  logic       m_to;

  int total = 0;
  int bad   = 0;

  logic [1:0] rb, rs;
  logic       rr, rd;

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_phase   = M_BAL;
    m_bal_age = 0;
    m_left    = 0;
    m_id_age  = 0;
    m_sel     = 2'b00;
    m_to      = 1'b0;
  endtask

  task automatic m_edge(input logic [1:0] b, input logic r, input logic [1:0] s, input logic d);
    logic trip;
    trip = 1'b0;
    case (m_phase)
      M_BAL: begin
        if (r && m_bal_age >= P_HOLD) begin
          m_phase = M_SET_ID;
          m_left  = P_SETTLE;
        end else begin
          m_bal_age++;
        end
      end
      M_SET_ID: begin
        m_left--;
        if (m_left == 0) begin
          if (r) begin
            m_phase  = M_ID;
            m_id_age = 0;
          end else begin
            m_phase = M_SET_BAL;
            m_left  = P_SETTLE;
          end
        end
      end
      M_ID: begin
        m_id_age++;
`ifdef FILTER_SCHED_TIMEOUT_EN
        if (m_id_age >= P_TO) begin
          trip = 1'b1;
          m_to = 1'b1;
        end
`endif
        if (d || !r || trip) begin
          m_phase = M_SET_BAL;
          m_left  = P_SETTLE;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_phase   = M_BAL;
          m_bal_age = 0;
        end
      end
    endcase
    m_sel = (m_phase == M_SET_ID || m_phase == M_ID) ? s : b;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_sel"}, bus.o_filter_select_out, m_sel);
    chk({tag, "_rdy"}, bus.o_ready, m_phase == M_ID);
    chk({tag, "_stl"}, bus.o_settling, m_phase == M_SET_ID || m_phase == M_SET_BAL);
`ifdef FILTER_SCHED_TIMEOUT_EN
    chk({tag, "_to"}, bus.o_timeout, m_to);
`endif
  endtask

  // Called on a falling edge: drive, take one rising edge, then compare on the next falling edge.
  task automatic step(input string tag, input logic [1:0] b, input logic r, input logic [1:0] s, input logic d);
    bus.i_bal_sel = b;
    bus.i_id_req  = r;
    bus.i_id_sel  = s;
    bus.i_id_done = d;
    @(posedge clk);
    m_edge(b, r, s, d);
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Reset raised between edges must clear the outputs before the next rising edge.
  task automatic async_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    m_reset();
    check_outputs({tag, "_async"});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs({tag, "_held"});
  endtask

  initial begin
    bus.i_bal_sel = 2'b00;
    bus.i_id_req  = 1'b0;
    bus.i_id_sel  = 2'b00;
    bus.i_id_done = 1'b0;
    m_reset();
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Balance only: selection follows bal_sel one cycle later, never settles.
    for (int k = 0; k < 100; k++) begin
      rb = (k >= 40 && k < 60) ? 2'b01 : 2'b10;
      step("bal_only", rb, 1'b0, 2'b11, 1'b0);
      chk("bal_only_follow", bus.o_filter_select_out, rb);
      chk("bal_only_noready", bus.o_ready, 1'b0);
    end

    // Identify asked from cycle 5: 32 hold edges, 8 settle cycles, ID on edge 41.
    async_reset("pre_id");
    for (int k = 1; k <= 41; k++) begin
      step("id_entry", 2'b10, k >= 5, 2'b01, 1'b0);
      if (k == 32) chk("id_entry_still_bal", bus.o_settling, 1'b0);
      if (k == 33) chk("id_entry_settle_start", bus.o_settling, 1'b1);
      if (k == 40) chk("id_entry_not_ready", bus.o_ready, 1'b0);
      if (k == 41) begin
        chk("id_entry_ready", bus.o_ready, 1'b1);
        chk("id_entry_sel", bus.o_filter_select_out, 2'b01);
      end
    end

    // id_done beats a still-high id_req; then 8 settle cycles and a fresh 32-cycle hold.
    step("done", 2'b11, 1'b1, 2'b01, 1'b1);
    chk("done_settling", bus.o_settling, 1'b1);
    chk("done_ready", bus.o_ready, 1'b0);
    chk("done_sel", bus.o_filter_select_out, 2'b11);
    for (int k = 1; k <= 8; k++) begin
      step("back_bal", 2'b11, 1'b1, 2'b01, 1'b0);
      chk("back_bal_settling", bus.o_settling, (k < 8) ? 2'b01 : 2'b00);
    end
    for (int k = 1; k <= 33; k++) begin
      step("rehold", 2'b10, 1'b1, 2'b01, 1'b0);
      chk("rehold_settling", bus.o_settling, (k == 33) ? 2'b01 : 2'b00);
    end

    // Requester drops out mid settle: window completes, ready never rises.
    step("drop", 2'b10, 1'b1, 2'b01, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step("drop", 2'b10, 1'b0, 2'b01, 1'b0);
      chk("drop_noready", bus.o_ready, 1'b0);
      chk("drop_sel", bus.o_filter_select_out, (k == 7) ? 2'b10 : 2'b01);
    end
    for (int k = 1; k <= 8; k++) begin
      step("drop_back", 2'b10, 1'b0, 2'b01, 1'b0);
      chk("drop_back_noready", bus.o_ready, 1'b0);
    end

    // Reset in the middle of an ID cycle.
    for (int k = 0; k < 100 && m_phase != M_ID; k++) begin
      step("to_id", 2'b10, 1'b1, 2'b01, 1'b0);
    end
    chk("reach_id", bus.o_ready, 1'b1);
    async_reset("rst_in_id");
    chk("rst_in_id_sel", bus.o_filter_select_out, 2'b00);

`ifdef FILTER_SCHED_TIMEOUT_EN
    // Watchdog: 20 ID cycles then forced back, flag sticks until reset.
    for (int k = 0; k < 100 && m_phase != M_ID; k++) begin
      step("wd_enter", 2'b10, 1'b1, 2'b01, 1'b0);
    end
    chk("wd_reach_id", bus.o_ready, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step("wd", 2'b10, 1'b1, 2'b01, 1'b0);
      chk("wd_flag", bus.o_timeout, (k == 20) ? 2'b01 : 2'b00);
    end
    chk("wd_settling", bus.o_settling, 1'b1);
    for (int k = 0; k < 30; k++) begin
      step("wd_sticky", 2'b10, 1'b0, 2'b01, 1'b0);
      chk("wd_sticky_flag", bus.o_timeout, 1'b1);
    end
    async_reset("wd_clear");
`endif

    // Random traffic: level-style id_req, sparse id_done pulses, occasional async reset.
    rr = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) rr = ~rr;
      rb = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      rd = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rand_rst");
      end else begin
        step("rand", rb, rr, rs, rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/filter_mode_scheduler.md
FILTER_MODE_SCHEDULER -- requirements
Module: filter_mode_scheduler

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8: settle-window length in clk cycles on every source change; legal values 1..255.
REQ-002 Parameter MIN_HOLD, default 32: minimum clk cycles the balance source owns the filter before identify may take it; legal values 1..1023.
REQ-003 Parameter ID_TIMEOUT, default 1000: identify watchdog limit in clk cycles; used only with FILTER_SCHED_TIMEOUT_EN; legal values 1..65535.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 bal_sel  input  2  filter selection requested by the balance loop.
REQ-007 id_req  input  1  level; identify requester wants the filter.
REQ-008 id_sel  input  2  filter selection requested by the identify logic.
REQ-009 id_done  input  1  one-cycle pulse; identify finished.
REQ-010 filter_select_out  output  2  registered filter selection driven to the filter bank.
REQ-011 ready  output  1  registered; 1 only while identify owns the filter (state ID).
REQ-012 settling  output  1  registered; 1 in either settle state.
REQ-013 timeout  output  1  sticky watchdog flag; present only with FILTER_SCHED_TIMEOUT_EN.

Function
REQ-014 FSM states SHALL be BAL, SET_ID, ID, SET_BAL, encoded in 2 bits.
REQ-015 BAL: filter_select_out <= bal_sel every cycle; hold counter increments and saturates at MIN_HOLD.
REQ-016 BAL -> SET_ID when id_req=1 and hold counter = MIN_HOLD; hold counter clears on entry to BAL.
REQ-017 SET_ID: filter_select_out <= id_sel; settle counter runs SETTLE_CYCLES cycles.
REQ-018 At settle expiry in SET_ID: go to ID if id_req=1, else go to SET_BAL.
REQ-019 ID: filter_select_out <= id_sel; go to SET_BAL when id_done=1 or id_req=0; id_done wins when both id_done=1 and id_req=1.
REQ-020 SET_BAL: filter_select_out <= bal_sel; after SETTLE_CYCLES cycles go to BAL; id_req is ignored in SET_BAL.
REQ-021 Input-to-output latency SHALL be one clk cycle in every state; no combinational path from inputs to outputs.
REQ-022 ready SHALL rise on the first ID cycle and fall on the first SET_BAL cycle.
REQ-023 id_done outside ID SHALL be ignored.
REQ-024 Settle counter reloads on every settle-state entry; counts never wrap.

Reset
REQ-025 rst=1 SHALL immediately force: state BAL, filter_select_out=2'b00, ready=0, settling=0, timeout=0, all counters 0.
REQ-026 Reset asserted mid-settle or in ID SHALL abandon the transfer with no residual state.
REQ-027 After rst deasserts, the first clk edge SHALL load bal_sel, and MIN_HOLD SHALL be counted from that edge.

Configuration
REQ-028 Macro FILTER_SCHED_TIMEOUT_EN defined: a watchdog counts ID cycles; on reaching ID_TIMEOUT the FSM goes to SET_BAL and timeout is set; timeout clears only on rst.
REQ-029 Macro undefined: no watchdog logic, no timeout port; ID may persist indefinitely.

Verification
REQ-030 Reset, then bal_sel=2'b10 and id_req=0 for 100 cycles -> filter_select_out=2'b10 one cycle after each change, ready=0, settling=0.
REQ-031 id_req=1 at cycle 5 after reset, id_sel=2'b01 -> stays BAL until hold=32, then 8 settling cycles, then ready=1 with out=2'b01.
REQ-032 In ID, pulse id_done with id_req=1 -> next cycle settling=1, ready=0, out=bal_sel; BAL after 8 cycles; re-entry requires 32 more cycles.
REQ-033 Drop id_req at cycle 3 of SET_ID -> SET_ID completes its 8 cycles, FSM passes to SET_BAL, ready never asserts.
REQ-034 Assert rst asynchronously (mid-cycle) during ID -> out=2'b00, ready=0 before the next clk edge.
REQ-035 With FILTER_SCHED_TIMEOUT_EN and ID_TIMEOUT=20, hold id_req=1 -> after 20 ID cycles timeout=1, FSM moves to SET_BAL, timeout stays 1 until rst.
